// File: rtl/multi_debounce_pkg.sv
// Shared constants, width helper and per-channel output bundle for multi_debounce.
package multi_debounce_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 10;
  localparam int DEF_LONG_TICKS   = 100;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } ch_out_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, tick-qualified stability counter, level and pulse flops.
// Long-press hold counter is present only with MULTI_DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  , parameter int LONG_TICKS = DEF_LONG_TICKS
`endif
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  input  logic    tick,
  output ch_out_t ch
);

  localparam int             CW       = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic          sync_s;
  logic [CW-1:0] cnt;
  logic          level, press, rel, lng;
  logic          accept;

  assign sync_s = sync_q[1];
  assign accept = (sync_s != level) && tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw ^ ACTIVE_LOW};
      press  <= 1'b0;
      rel    <= 1'b0;
      // Any agreeing sample throws away a pending change.
      if (sync_s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_s;
        cnt   <= '0;
        press <= sync_s;
        rel   <= ~sync_s;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int            HW        = cnt_width(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_TICKS - 1);

  logic [HW-1:0] hold;

  // Held at zero while released and on the release edge, so each press starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      lng  <= 1'b0;
    end else begin
      lng <= 1'b0;
      if (!level || accept) begin
        hold <= '0;
      end else if (tick && hold != HOLD_LAST) begin
        hold <= hold + 1'b1;
        lng  <= (hold == HOLD_FIRE);
      end
    end
  end
`else
  assign lng = 1'b0;
`endif

  assign ch = '{level: level, press: press, rel: rel, lng: lng};

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer: one shared tick prescaler fanned out to CHANNELS debounce_channel lanes.
// Optional long-press pulse: define MULTI_DEBOUNCE_LONG_PRESS_EN.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (CHANNELS < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_param_err
    $error("multi_debounce: illegal parameter value");
  end

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ch_out_t o;

    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
      , .LONG_TICKS (LONG_TICKS)
`endif
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .tick (tick),
      .ch   (o)
    );

    assign btn_level[i]     = o.level;
    assign press_pulse[i]   = o.press;
    assign release_pulse[i] = o.rel;
    assign long_pulse[i]    = o.lng;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: per-cycle reference model, vector table, directed corner sequences, random soak.
module tb_multi_debounce;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_raw;
  logic [CH-1:0] btn_level, press_pulse, release_pulse, long_pulse;

  multi_debounce #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0), .LONG_TICKS(LT)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: edges are numbered from the reset edge, ticks land where e%TD==TD-1,
  // and acceptance asks how many ticks fell inside the current disagreement run.
  logic [CH-1:0] mq[$];
  int            e;
  logic [CH-1:0] m_lvl, m_press, m_rel, m_long;
  int            run_start[CH];
  int            press_edge[CH];

  function automatic int ticks_upto(input int x);
    return (x + 1) / TD;
  endfunction

  task automatic model_edge(input logic [CH-1:0] r, input logic rs);
    logic [CH-1:0] s;
    bit            tk, acc;
    if (rs) begin
      mq.delete();
      e = 0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin run_start[c] = -1; press_edge[c] = 0; end
      return;
    end
    s  = (mq.size() == 2) ? mq[0] : '0;
    tk = (e % TD) == TD - 1;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      if (s[c] == m_lvl[c]) run_start[c] = -1;
      else begin
        if (run_start[c] < 0) run_start[c] = e;
        if (tk && (ticks_upto(e) - ticks_upto(run_start[c] - 1)) == ST) acc = 1;
      end
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
      if (m_lvl[c] && !acc && tk && (ticks_upto(e) - ticks_upto(press_edge[c])) == LT)
        m_long[c] = 1'b1;
`endif
      if (acc) begin
        m_lvl[c]     = s[c];
        m_press[c]   = s[c];
        m_rel[c]     = ~s[c];
        run_start[c] = -1;
        if (s[c]) press_edge[c] = e;
      end
    end
    if (mq.size() == 2) void'(mq.pop_front());
    mq.push_back(r);
    e++;
  endtask

  // Per-step bookkeeping for the directed sequences.
  int cyc = 0;
  int np[CH], nr[CH], nl[CH];
  int press_cyc[CH], rel_cyc[CH], long_cyc[CH];

  task automatic clr_counts();
    for (int c = 0; c < CH; c++) begin
      np[c] = 0; nr[c] = 0; nl[c] = 0;
      press_cyc[c] = -1; rel_cyc[c] = -1; long_cyc[c] = -1;
    end
  endtask

  task automatic step(input logic [CH-1:0] r, input logic rs);
    btn_raw = r;
    rst     = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    cyc++;
    chk("cycle_model", {btn_level, press_pulse, release_pulse, long_pulse},
        {m_lvl, m_press, m_rel, m_long});
    for (int c = 0; c < CH; c++) begin
      if (press_pulse[c])   begin np[c]++; press_cyc[c] = cyc; end
      if (release_pulse[c]) begin nr[c]++; rel_cyc[c]   = cyc; end
      if (long_pulse[c])    begin nl[c]++; long_cyc[c]  = cyc; end
    end
  endtask

  typedef struct {
    logic [CH-1:0] raw;
    int            cycles;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rls;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat, t0;
    logic [CH-1:0] r;
    int flip_div;

    vt[0] = '{2'b01, 20, 2'b01, 2'b01, 2'b00};
    vt[1] = '{2'b11, 20, 2'b11, 2'b10, 2'b00};
    vt[2] = '{2'b10, 20, 2'b10, 2'b00, 2'b01};
    vt[3] = '{2'b11,  6, 2'b10, 2'b00, 2'b00};
    vt[4] = '{2'b10, 20, 2'b10, 2'b00, 2'b00};
    vt[5] = '{2'b00, 20, 2'b00, 2'b00, 2'b10};
    vt[6] = '{2'b01,  7, 2'b00, 2'b00, 2'b00};
    vt[7] = '{2'b00, 20, 2'b00, 2'b00, 2'b00};

    btn_raw = '0;
    rst     = 1'b1;
    step('0, 1'b1);
    step('0, 1'b1);
    chk("reset_state", {btn_level, press_pulse, release_pulse, long_pulse}, 0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      clr_counts();
      repeat (vt[i].cycles) step(vt[i].raw, 1'b0);
      chk($sformatf("vec%0d_level", i), btn_level, vt[i].lvl);
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("vec%0d_press%0d", i, c), np[c], vt[i].prs[c]);
        chk($sformatf("vec%0d_release%0d", i, c), nr[c], vt[i].rls[c]);
      end
    end

    // Clean press: prescaler restarts at reset, so ticks fall on edges 3,7,11 -> 12 steps
    step('0, 1'b1);
    clr_counts();
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      step(2'b01, 1'b0);
      if (btn_level[0] && lat < 0) lat = n;
    end
    chk("clean_latency", lat, 12);
    chk("clean_press_once", np[0], 1);

    // Bounce every 5 clocks, then hold
    step('0, 1'b1);
    clr_counts();
    for (int i = 0; i < 40; i++) step(((i / 5) % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
    repeat (30) step(2'b01, 1'b0);
    chk("bounce_press_count", np[0], 1);
    chk("bounce_release_count", nr[0], 0);

    // Glitch on ch1 for 8 clocks
    clr_counts();
    repeat (8) step(2'b11, 1'b0);
    repeat (30) step(2'b01, 1'b0);
    chk("glitch_level1", btn_level[1], 0);
    chk("glitch_pulses1", np[1] + nr[1], 0);

    // Simultaneous press ch0 / release ch1
    repeat (20) step(2'b10, 1'b0);
    chk("simul_setup_level", btn_level, 2'b10);
    clr_counts();
    repeat (20) step(2'b01, 1'b0);
    chk("simul_press0", np[0], 1);
    chk("simul_release1", nr[1], 1);
    chk("simul_same_cycle", press_cyc[0], rel_cyc[1]);

    // Reset two ticks into a pending press
    step('0, 1'b1);
    clr_counts();
    repeat (9) step(2'b01, 1'b0);
    chk("rst_mid_pending_level", btn_level[0], 0);
    step(2'b01, 1'b1);
    chk("rst_mid_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 0);
    chk("rst_mid_no_release", nr[0], 0);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      step(2'b01, 1'b0);
      if (btn_level[0] && lat < 0) lat = n;
    end
    chk("rst_mid_full_restart", lat, 12);

    // Long hold
    step('0, 1'b1);
    clr_counts();
    repeat (120) step(2'b01, 1'b0);
    t0 = press_cyc[0];
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
    chk("long_once", nl[0], 1);
    chk("long_delay", long_cyc[0] - t0, LT * TD);
`else
    chk("long_tied_low", nl[0] + nl[1], 0);
`endif
    clr_counts();
    repeat (20) step(2'b00, 1'b0);
    repeat (60) step(2'b01, 1'b0);
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
    chk("long_after_repress", nl[0], 1);
`else
    chk("long_tied_low_repress", nl[0] + nl[1], 0);
`endif

    // Random soak against the model, alternating noisy and calm phases
    step('0, 1'b1);
    r = '0;
    for (int blk = 0; blk < 10; blk++) begin
      flip_div = (blk % 2 == 0) ? 3 : 30;
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(flip_div - 1) == 0) r[c] = ~r[c];
        step(r, ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
